mem_bus_arbiter: RTL

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

---
 rtl/rv32_bus_pkg.sv | 22 ++
 rtl/mem_arb_pick.sv | 44 ++++
 rtl/mem_bus_arbiter.sv | 132 +++++++++++++
 3 files changed

// File: rtl/rv32_bus_pkg.sv
// Shared definitions for the RV32 memory bus arbiter: FSM encoding, owner
// identifiers and the default fetch starvation limit.
package rv32_bus_pkg;

    localparam int STARVE_LIMIT_DEFAULT = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CMD  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    // Counter width able to hold 0..limit, never narrower than one bit.
    function automatic int starveWidth(input int limit);
        return (limit < 2) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Grant selection between fetch and data requesters, with a saturating
// counter that lets a waiting fetch win after STARVE_LIMIT data grants.
module mem_arb_pick
    import rv32_bus_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   iReq,
    input  logic   dReq,
    input  logic   grantEn,
    output logic   grantValid,
    output owner_t grantOwner
);

    localparam int CNT_W = starveWidth(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starveCnt;
    logic             starved;

    // Data normally wins; fetch takes over only once it has been passed over LIMIT times.
    always_comb begin
        starved    = iReq && dReq && (starveCnt == LIMIT);
        grantValid = grantEn && (iReq || dReq);
        grantOwner = (dReq && !starved) ? OWN_D : OWN_I;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starveCnt <= '0;
        end else if (grantValid) begin
            if ((grantOwner == OWN_D) && iReq) begin
                if (starveCnt != LIMIT) begin
                    starveCnt <= starveCnt + CNT_W'(1);
                end
            end else begin
                starveCnt <= '0;
            end
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Single-outstanding arbiter sharing one memory port between the fetch and
// memory stages of an RV32 pipeline.
module mem_bus_arbiter
    import rv32_bus_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [3:0]        d_wstrb,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              stall_f,
    output logic              stall_m,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    output logic [3:0]        m_wstrb,
    input  logic              m_rvalid,
    input  logic [DATA_W-1:0] m_rdata
);

    logic [1:0] state;
    owner_t     owner;
    logic       grantEn;
    logic       grantValid;
    owner_t     grantOwner;

    assign grantEn = (state == ST_IDLE);
    assign stall_f = i_req & ~i_ack;
    assign stall_m = d_req & ~d_ack;

    mem_arb_pick #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) uPick (
        .clk       (clk),
        .reset     (reset),
        .iReq      (i_req),
        .dReq      (d_req),
        .grantEn   (grantEn),
        .grantValid(grantValid),
        .grantOwner(grantOwner)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            owner <= OWN_I;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grantValid) begin
                        state <= ST_CMD;
                        owner <= grantOwner;
                    end
                end
                ST_CMD: begin
                    if (m_valid && m_ready) begin
                        state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (m_rvalid) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Command fields are captured once at grant and held until the next grant.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_valid <= 1'b0;
            m_we    <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
            m_wstrb <= '0;
        end else if (grantValid) begin
            m_valid <= 1'b1;
            if (grantOwner == OWN_D) begin
                m_we    <= d_we;
                m_addr  <= d_addr;
                m_wdata <= d_wdata;
                m_wstrb <= d_wstrb;
            end else begin
                m_we    <= 1'b0;
                m_addr  <= i_addr;
                m_wdata <= '0;
                m_wstrb <= '0;
            end
        end else if ((state == ST_CMD) && m_ready) begin
            m_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            i_ack   <= 1'b0;
            d_ack   <= 1'b0;
            i_rdata <= '0;
            d_rdata <= '0;
        end else begin
            i_ack <= 1'b0;
            d_ack <= 1'b0;
            if ((state == ST_RESP) && m_rvalid) begin
                if (owner == OWN_D) begin
                    d_rdata <= m_rdata;
                    d_ack   <= 1'b1;
                end else begin
                    i_rdata <= m_rdata;
                    i_ack   <= 1'b1;
                end
            end
        end
    end

endmodule
